// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//  Shares one single-port RAM between the CPU memory port (port 0) and the
//  program-loader/debug port (port 1). A request is captured in IDLE, the
//  winner holds the RAM for MEM_LAT cycles (ACCESS), then gets a one-cycle
//  ack with its read data (DONE). Ties are broken round-robin.
//
//  Ports
//   clk, reset          clock (posedge) and synchronous active-high reset
//   req/we/addr/wdata0  port 0 request, write flag, address, write data
//   gnt0/ack0/rdata0    port 0 ownership, completion pulse, read data
//   req/we/addr/wdata1  port 1 request (same meaning as port 0)
//   gnt1/ack1/rdata1    port 1 ownership, completion pulse, read data
//   mem_en/mem_we       RAM enable / write enable (high only in ACCESS)
//   mem_addr/mem_wdata  RAM address / write data (stable through ACCESS)
//   mem_rdata           RAM read data, sampled on the last ACCESS cycle
// ----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]        state, state_d;
   logic              last_gnt, last_gnt_d;
   logic              owner, owner_d;
   logic [CNT_W-1:0]  lat_cnt, lat_cnt_d;
   logic              gnt0_d, gnt1_d, ack0_d, ack1_d;
   logic [DATA_W-1:0] rdata0_d, rdata1_d;
   logic              mem_en_d, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_d;
   logic              win_c;

   // Lone requester wins; on a tie the port that did not win last time wins.
   assign win_c = req1 & (~req0 | ~last_gnt);

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         last_gnt  <= 1'b1;
         owner     <= 1'b0;
         lat_cnt   <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state     <= state_d;
         last_gnt  <= last_gnt_d;
         owner     <= owner_d;
         lat_cnt   <= lat_cnt_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         ack0      <= ack0_d;
         ack1      <= ack1_d;
         rdata0    <= rdata0_d;
         rdata1    <= rdata1_d;
         mem_en    <= mem_en_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

   // Next state and next output values.
   always_comb begin
      state_d     = state;
      last_gnt_d  = last_gnt;
      owner_d     = owner;
      lat_cnt_d   = lat_cnt;
      gnt0_d      = gnt0;
      gnt1_d      = gnt1;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rdata0_d    = rdata0;
      rdata1_d    = rdata1;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;

      case (state)
         S_IDLE: begin
            gnt0_d = 1'b0;
            gnt1_d = 1'b0;
            if (req0 || req1) begin
               // The RAM-side registers double as the request latch.
               state_d     = S_ACCESS;
               owner_d     = win_c;
               last_gnt_d  = win_c;
               lat_cnt_d   = '0;
               gnt0_d      = ~win_c;
               gnt1_d      = win_c;
               mem_en_d    = 1'b1;
               mem_we_d    = win_c ? we1 : we0;
               mem_addr_d  = win_c ? addr1 : addr0;
               mem_wdata_d = win_c ? wdata1 : wdata0;
            end
         end

         S_ACCESS: begin
            if (lat_cnt == LAST_CNT) begin
               state_d = S_DONE;
               if (owner) begin
                  rdata1_d = mem_rdata;
                  ack1_d   = 1'b1;
               end else begin
                  rdata0_d = mem_rdata;
                  ack0_d   = 1'b1;
               end
            end else begin
               lat_cnt_d = lat_cnt + CNT_W'(1);
               mem_en_d  = 1'b1;
               mem_we_d  = mem_we;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//  Self-checking bench for mem_arbiter: a table of single accesses, hand
//  sequences for the multi-cycle corners, and MEM_LAT=1/4 latency builds.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int LAT = 2;

   typedef struct {
      logic       port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic       port;
      logic       we;
      logic [7:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, ram_init;
   logic       req0, we0, req1, we1;
   logic [7:0] addr0, wdata0, addr1, wdata1;
   logic       gnt0, ack0, gnt1, ack1;
   logic [7:0] rdata0, rdata1;
   logic       mem_en, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0] ram [256];

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs[8];

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // RAM model: writes on the clock edge, combinational read.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
         ram[8'h10] <= 8'h5A;
         ram[8'h40] <= 8'h77;
      end else if (mem_en && mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = ram[mem_addr];

   // Latency builds: port 0 only, constant RAM data.
   logic       t6_req;
   logic       l1_gnt0, l1_ack0, l1_gnt1, l1_ack1, l1_en, l1_we;
   logic [7:0] l1_rd0, l1_rd1, l1_addr, l1_wd;
   logic       l4_gnt0, l4_ack0, l4_gnt1, l4_ack1, l4_en, l4_we;
   logic [7:0] l4_rd0, l4_rd1, l4_addr, l4_wd;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .req0(t6_req), .we0(1'b0), .addr0(8'h22), .wdata0(8'h00),
      .gnt0(l1_gnt0), .ack0(l1_ack0), .rdata0(l1_rd0),
      .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00),
      .gnt1(l1_gnt1), .ack1(l1_ack1), .rdata1(l1_rd1),
      .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_addr),
      .mem_wdata(l1_wd), .mem_rdata(8'hC3)
   );

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(4)) u_lat4 (
      .clk(clk), .reset(reset),
      .req0(t6_req), .we0(1'b0), .addr0(8'h33), .wdata0(8'h00),
      .gnt0(l4_gnt0), .ack0(l4_ack0), .rdata0(l4_rd0),
      .req1(1'b0), .we1(1'b0), .addr1(8'h00), .wdata1(8'h00),
      .gnt1(l4_gnt1), .ack1(l4_ack1), .rdata1(l4_rd1),
      .mem_en(l4_en), .mem_we(l4_we), .mem_addr(l4_addr),
      .mem_wdata(l4_wd), .mem_rdata(8'h96)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock: sample at negedge, check invariants, retire acks vs scoreboard.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      checks++;
      if ((gnt0 && gnt1) || (ack0 && ack1) || (mem_en && !(gnt0 || gnt1)) || (mem_we && !mem_en)) begin
         errors++;
         $display("FAIL invariant: gnt=%b%b ack=%b%b en=%b we=%b at %0t",
                  gnt0, gnt1, ack0, ack1, mem_en, mem_we, $time);
      end
      if (ack0 || ack1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: ack0=%b ack1=%b with empty scoreboard at %0t", ack0, ack1, $time);
         end else begin
            e = sb.pop_front();
            chk("sb_port", 32'(ack1), 32'(e.port));
            if (!e.we) chk("sb_rdata", 32'(ack1 ? rdata1 : rdata0), 32'(e.rdata));
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      chk(name, {gnt0, gnt1, ack0, ack1, mem_en, mem_we, rdata0, rdata1},
          32'h0);
      chk({name, "_mem"}, {mem_addr, mem_wdata}, 32'h0);
   endtask

   // Single access on one port; checks latency, RAM-side values and ack width.
   task automatic do_access(input vec_t v);
      int   cyc = 0;
      int   en_cnt = 0;
      logic ram_ok = 1'b1;
      logic gnt_ok = 1'b0;
      logic done = 1'b0;
      if (v.port) begin
         req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
      end else begin
         req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
      end
      sb.push_back('{port: v.port, we: v.we, rdata: v.exp_rdata});
      while (!done) begin
         tick();
         cyc++;
         if (cyc == 1) gnt_ok = v.port ? gnt1 : gnt0;
         if (mem_en) begin
            en_cnt++;
            if (mem_addr != v.addr || mem_we != v.we || (v.we && mem_wdata != v.wdata)) ram_ok = 1'b0;
         end
         if (v.port ? ack1 : ack0) done = 1'b1;
         else if (cyc >= 20) begin
            done = 1'b1;
            chk("ack_timeout", 32'(cyc), 32'(LAT + 1));
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("ack_latency", 32'(cyc), 32'(LAT + 1));
      chk("grant", 32'(gnt_ok), 32'h1);
      chk("mem_en_cycles", 32'(en_cnt), 32'(LAT));
      chk("mem_side_values", 32'(ram_ok), 32'h1);
      tick();
      chk("ack_one_cycle", 32'(v.port ? ack1 : ack0), 32'h0);
   endtask

   // Both ports request continuously; grants must alternate starting at port 0.
   task automatic run_both(input int n);
      int acks = 0;
      int cyc = 0;
      int last = 0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h80;
      for (int i = 0; i < n; i++)
         sb.push_back('{port: 1'(i % 2), we: 1'b0, rdata: (i % 2) ? 8'h3C : 8'h5A});
      while (acks < n && cyc < n * (LAT + 2) + 10) begin
         tick();
         cyc++;
         if (ack0 || ack1) begin
            if (acks > 0) chk("ack_spacing", 32'(cyc - last), 32'(LAT + 2));
            last = cyc;
            acks++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_ack_count", 32'(acks), 32'(n));
      tick();
      tick();
   endtask

   initial begin
      int first1, first4, en4;
      vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'h5A};
      vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'h80, wdata: 8'h3C, exp_rdata: 8'h00};
      vecs[2] = '{port: 1'b0, we: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h3C};
      vecs[3] = '{port: 1'b1, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'h5A};
      vecs[4] = '{port: 1'b0, we: 1'b1, addr: 8'hFF, wdata: 8'hA5, exp_rdata: 8'h00};
      vecs[5] = '{port: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'hA5};
      vecs[6] = '{port: 1'b1, we: 1'b0, addr: 8'h40, wdata: 8'h00, exp_rdata: 8'h77};
      vecs[7] = '{port: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h00};

      reset = 1'b1; ram_init = 1'b1; t6_req = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
      req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
      repeat (3) tick();
      check_all_zero("reset_state");
      reset = 1'b0; ram_init = 1'b0;
      tick();

      // Table of single accesses (includes read, write, read-back).
      for (int i = 0; i < 8; i++) do_access(vecs[i]);

      // Address change and req drop during ACCESS are ignored.
      sb.push_back('{port: 1'b0, we: 1'b0, rdata: 8'h5A});
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
      tick();
      chk("t4_addr_c1", 32'(mem_addr), 32'h10);
      addr0 = 8'h20; req0 = 1'b0;
      tick();
      chk("t4_en_c2", 32'(mem_en), 32'h1);
      chk("t4_addr_c2", 32'(mem_addr), 32'h10);
      tick();
      chk("t4_ack", 32'(ack0), 32'h1);
      begin
         int extra = 0;
         for (int i = 0; i < 5; i++) begin
            tick();
            if (ack0 || gnt0) extra++;
         end
         chk("t4_no_reaccess", 32'(extra), 32'h0);
      end

      // Reset on the second ACCESS cycle: no ack, everything cleared.
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
      tick();
      tick();
      chk("t5_in_access", 32'(mem_en), 32'h1);
      reset = 1'b1;
      tick();
      req0 = 1'b0;
      check_all_zero("t5_reset_mid");
      tick();
      reset = 1'b0;
      tick();
      check_all_zero("t5_after_release");

      // Simultaneous requests after reset: 0,1,0,1,0,1.
      run_both(6);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      // MEM_LAT=1 and MEM_LAT=4 builds.
      first1 = 0; first4 = 0; en4 = 0;
      t6_req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 6) t6_req = 1'b0;
         if (l4_en && first4 == 0) en4++;
         if (l1_ack0 && first1 == 0) begin
            first1 = c;
            chk("t6_lat1_rdata", 32'(l1_rd0), 32'hC3);
         end
         if (l4_ack0 && first4 == 0) begin
            first4 = c;
            chk("t6_lat4_rdata", 32'(l4_rd0), 32'h96);
         end
         if (l1_gnt1 || l1_ack1 || l4_gnt1 || l4_ack1 || l1_we || l4_we)
            chk("t6_port1_idle", 32'h1, 32'h0);
      end
      chk("t6_lat1_ack", 32'(first1), 32'h2);
      chk("t6_lat4_ack", 32'(first4), 32'h5);
      chk("t6_lat4_en", 32'(en4), 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
